cursor_ctrl: RTL
================

// Module: cursor_ctrl
// PURPOSE
//  Upstream stage of game_state. Turns the raw board push-buttons into a debounced
//  10x10 grid cursor (sprite_row/sprite_col) and a one-cycle fire pulse for game_state.btn_c.
//  Directional buttons auto-repeat while held. Fire is suppressed once the game ends.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   cycles a synced input must disagree with its stable state before it flips
//  REPEAT_DELAY     40_000_000  cycles from a direction press event to the first auto-repeat event
//  REPEAT_PERIOD    15_000_000  cycles between subsequent auto-repeat events
//  START_ROW        0           cursor row after reset (0..9)
//  START_COL        0           cursor col after reset (0..9)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  btn_u       in   1  raw up button (asynchronous, bouncy)
//  btn_d       in   1  raw down button
//  btn_l       in   1  raw left button
//  btn_r       in   1  raw right button
//  btn_c       in   1  raw fire button
//  lock        in   1  game over (game_state win|lose). 1 = fire suppressed, moves allowed
//  sprite_row  out  4  cursor row 0..9, registered
//  sprite_col  out  4  cursor col 0..9, registered
//  fire        out  1  one-cycle fire pulse, registered
// BEHAVIOUR
//  - Reset (reset=0): sprite_row=START_ROW, sprite_col=START_COL, fire=0. All sync, debounce and
//    repeat state is cleared and stable states read 0. Takes effect immediately, including mid-hold.
//    After release, a button still held must be seen as a fresh press.
//  - Per button: 2-flop synchronizer, then debounce counter. The counter increments while the synced
//    value != stable and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 and
//    they still differ, stable takes the synced value and the counter clears.
//  - Press event: rising edge of stable (one cycle). Release produces no event.
//  - Latency: raw input held high from edge 0 -> fire (or the coordinate change) is visible after
//    edge DEBOUNCE_CYCLES+3.
//  - Auto-repeat (u/d/l/r only): the repeat counter starts at the press event. The first repeat event
//    fires REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles while stable
//    stays 1. The counter clears on release. btn_c never repeats.
//  - Move event = press or repeat event. Up: row-1. Down: row+1. Left: col-1. Right: col+1.
//  - Row and col axes are independent. up+down (or left+right) events in the same cycle cancel, so that
//    axis does not change. Moves on different axes in the same cycle both apply.
//  - Arithmetic is 4-bit. Results are always 0..9, with no out-of-range value ever visible.
//  - fire = 1 for exactly one cycle per btn_c press event when lock=0.
//    - lock=1 in the press-event cycle: no pulse, and the press is not queued for later.
//  - Fire priority: a move event in the same cycle as a fire press event is dropped. Coordinates are
//    held stable in the fire cycle and the cycle after it, so game_state samples a steady cell.
//  - lock does not affect cursor movement.
// CONFIGURATION
//  CURSOR_WRAP_EN defined:   up at row 0 -> 9, down at row 9 -> 0, left at col 0 -> 9, right at col 9 -> 0.
//  CURSOR_WRAP_EN undefined: edges clamp (moves past 0 or 9 are ignored, position unchanged).
// STRUCTURE
//  - Shared package battleship_pkg holds:
//    - GRID_N=10
//    - COORD_W=4
//    - localparam GRID_MAX=GRID_N-1
//    - the cell status codes (EMPTY=2'b00, MISS=2'b01, HIT=2'b10, SUNK=2'b11)
//  - Sub-module btn_debounce (sync + debounce + press-event edge), instantiated 5x.
//  - The auto-repeat counters and the cursor update logic live in cursor_ctrl.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, START=0,0)
//  1. Drive reset=0 while btn_d has been held 30 cycles (row=2)
//     -> same cycle row=0, col=0, fire=0. Release reset with btn_d still high -> row=1 after 7 cycles.
//  2. btn_r toggles every 2 cycles for 20 cycles, then holds high 10 cycles, then low
//     -> col goes 0->1 exactly once, with no repeat.
//  3. col=9, press btn_r -> col=0 with CURSOR_WRAP_EN, col=9 without.
//     row=0, press btn_u -> row=9 / row=0 respectively.
//  4. Hold btn_d 60 cycles past its press event -> row increments at press, +20, +28, +36, +44, +52
//     (row=6). Release, then hold again -> counting restarts from a fresh press.
//  5. Hold btn_c 100 cycles with lock=0 -> exactly one fire pulse, row/col unchanged.
//     Repeat with lock=1 -> no pulse. Drop lock while held -> still no pulse.
//  6. btn_u+btn_d press events in the same cycle -> row unchanged.
//     btn_u+btn_r from (5,5) -> (4,6).
//     btn_c+btn_r in the same event cycle -> fire pulse with col unchanged.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared battleship constants, cell codes and the cursor axis step helper.
// CURSOR_WRAP_EN: when defined the cursor wraps at grid edges, otherwise it clamps.
package battleship_pkg;

    localparam int GRID_N   = 10;
    localparam int COORD_W  = 4;
    localparam int GRID_MAX = GRID_N - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        MISS  = 2'b01,
        HIT   = 2'b10,
        SUNK  = 2'b11
    } cell_e;

    // One axis update; simultaneous inc and dec cancel.
    function automatic logic [COORD_W-1:0] coord_step(input logic [COORD_W-1:0] c,
                                                      input logic inc,
                                                      input logic dec);
        logic [COORD_W-1:0] r;
        r = c;
        if (inc && !dec) begin
            if (c == COORD_W'(GRID_MAX)) begin
`ifdef CURSOR_WRAP_EN
                r = '0;
`else
                r = c;
`endif
            end else begin
                r = c + COORD_W'(1);
            end
        end else if (dec && !inc) begin
            if (c == '0) begin
`ifdef CURSOR_WRAP_EN
                r = COORD_W'(GRID_MAX);
`else
                r = c;
`endif
            end else begin
                r = c - COORD_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter, registered press pulse.
// held_o is the stable level delayed to line up with press_o.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic held_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;
    logic             dly_q;
    logic             press_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            dly_q    <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            dly_q   <= stable_q;
            press_q <= stable_q & ~dly_q;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign held_o  = dly_q;
    assign press_o = press_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Debounced 10x10 grid cursor with direction auto-repeat and a lockable fire pulse.
// CURSOR_WRAP_EN (see battleship_pkg) selects wrap vs clamp at the grid edges.
module cursor_ctrl
    import battleship_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 40_000_000,
    parameter int unsigned REPEAT_PERIOD   = 15_000_000,
    parameter int unsigned START_ROW       = 0,
    parameter int unsigned START_COL       = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               btn_c,
    input  logic               lock,
    output logic [COORD_W-1:0] sprite_row,
    output logic [COORD_W-1:0] sprite_col,
    output logic               fire
);

    localparam int DIR_U = 0, DIR_D = 1, DIR_L = 2, DIR_R = 3;
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [3:0]            dir_raw, held, press, rep_ev, mv;
    logic [3:0][REP_W-1:0] rep_q;
    logic                  held_c, press_c;
    logic [COORD_W-1:0]    row_q, row_d, col_q, col_d;
    logic                  fire_q, fire_d, freeze;

    assign dir_raw = {btn_r, btn_l, btn_d, btn_u};

    for (genvar g = 0; g < 4; g++) begin : g_dir
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (clk),
            .rst_ni (reset),
            .btn_i  (dir_raw[g]),
            .held_o (held[g]),
            .press_o(press[g])
        );
        assign rep_ev[g] = held[g] & ~press[g] & (rep_q[g] == REP_FIRST);
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk_i  (clk),
        .rst_ni (reset),
        .btn_i  (btn_c),
        .held_o (held_c),
        .press_o(press_c)
    );

    // Moves are dropped in the press cycle of a fire and while fire is high,
    // so the coordinates stay put across the fire cycle and the one after it.
    always_comb begin
        mv     = press | rep_ev;
        fire_d = press_c & held_c & ~lock;
        freeze = fire_d | fire_q;
        row_d  = row_q;
        col_d  = col_q;
        if (!freeze) begin
            row_d = coord_step(row_q, mv[DIR_D], mv[DIR_U]);
            col_d = coord_step(col_q, mv[DIR_R], mv[DIR_L]);
        end
    end

    // Repeat counter: 1 the cycle after a press, hits REPEAT_DELAY, then reloads
    // so the next hit lands REPEAT_PERIOD cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q  <= '0;
            row_q  <= COORD_W'(START_ROW);
            col_q  <= COORD_W'(START_COL);
            fire_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!held[i])                 rep_q[i] <= '0;
                else if (press[i])            rep_q[i] <= REP_W'(1);
                else if (rep_q[i] == REP_FIRST) rep_q[i] <= REP_RELOAD;
                else                          rep_q[i] <= rep_q[i] + REP_W'(1);
            end
            row_q  <= row_d;
            col_q  <= col_d;
            fire_q <= fire_d;
        end
    end

    assign sprite_row = row_q;
    assign sprite_col = col_q;
    assign fire       = fire_q;

endmodule
